// File: rtl/l2_cache_miss_tracker_if.sv
// Lookup/response bundle between the L2 read stage and the pending-miss tracker.
// The upstream pipeline is the master; the tracker is the slave.
interface l2_cache_miss_tracker_if #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 20,
  parameter int MERGE_WIDTH = 3,
  localparam int IDX_WIDTH  = $clog2(NUM_ENTRIES)
);
  logic                   lookup_valid;
  logic [KEY_WIDTH-1:0]   lookup_addr;
  logic                   lookup_is_miss;
  logic                   lookup_is_fill;
  logic                   flush_en;
  logic                   duplicate_request;
  logic [IDX_WIDTH-1:0]   lookup_idx;
  logic [MERGE_WIDTH-1:0] merge_count;
  logic [IDX_WIDTH:0]     occupancy;
  logic                   tracker_full;
  logic                   alloc_error;
  logic                   orphan_fill_error;
  logic                   merge_sat_error;

  modport master (
    output lookup_valid, lookup_addr, lookup_is_miss, lookup_is_fill, flush_en,
    input  duplicate_request, lookup_idx, merge_count, occupancy, tracker_full,
           alloc_error, orphan_fill_error, merge_sat_error
  );

  modport slave (
    input  lookup_valid, lookup_addr, lookup_is_miss, lookup_is_fill, flush_en,
    output duplicate_request, lookup_idx, merge_count, occupancy, tracker_full,
           alloc_error, orphan_fill_error, merge_sat_error
  );
endinterface

// File: rtl/l2_cache_miss_tracker.sv
// Pending-miss tracker: one entry per line with an outstanding memory load,
// merge counting for duplicate requests, occupancy and early backpressure.

module l2_miss_entry #(
  parameter int KEY_WIDTH   = 20,
  parameter int MERGE_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   alloc,
  input  logic                   rel,
  input  logic                   merge,
  input  logic [KEY_WIDTH-1:0]   key_in,
  output logic                   vld,
  output logic [KEY_WIDTH-1:0]   key,
  output logic [MERGE_WIDTH-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vld <= 1'b0;
      key <= '0;
      cnt <= '0;
    end else if (alloc) begin
      vld <= 1'b1;
      key <= key_in;
      cnt <= '0;
    end else if (rel) begin
      vld <= 1'b0;
      cnt <= '0;
    end else if (merge && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module l2_cache_miss_tracker #(
  parameter int NUM_ENTRIES = 16,
  // Width of cache_line_index_t in the L2 pipeline.
  parameter int KEY_WIDTH   = 20,
  parameter int FULL_MARGIN = 4,
  parameter int MERGE_WIDTH = 3,
  localparam int IDX_WIDTH  = $clog2(NUM_ENTRIES)
) (
  input logic                  clk,
  input logic                  reset,
  l2_cache_miss_tracker_if.slave bus
);
  localparam logic [IDX_WIDTH:0] FULL_LEVEL = (IDX_WIDTH+1)'(NUM_ENTRIES - FULL_MARGIN);

  logic [NUM_ENTRIES-1:0]                  ent_vld;
  logic [NUM_ENTRIES-1:0][KEY_WIDTH-1:0]   ent_key;
  logic [NUM_ENTRIES-1:0][MERGE_WIDTH-1:0] ent_cnt;
  logic [NUM_ENTRIES-1:0]                  match;

  logic                 hit, any_free;
  logic [IDX_WIDTH-1:0] match_idx, free_idx;
  logic                 do_alloc, do_rel, do_merge;
  logic                 set_alloc_err, set_orphan_err, set_sat_err;
  logic [IDX_WIDTH:0]   occ_q, occ_next;
  logic                 full_q, alloc_err_q, orphan_err_q, sat_err_q;

  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    any_free  = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = ent_vld[i] && (ent_key[i] == bus.lookup_addr);
      if (match[i]) match_idx = IDX_WIDTH'(i);
    end
    // Walk downwards so the lowest invalid slot is the one that sticks.
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        free_idx = IDX_WIDTH'(i);
        any_free = 1'b1;
      end
    end
  end

  assign hit = |match;

  // A flush overrides whatever lookup arrives with it.
  always_comb begin
    do_rel         = 1'b0;
    do_merge       = 1'b0;
    do_alloc       = 1'b0;
    set_alloc_err  = 1'b0;
    set_orphan_err = 1'b0;
    set_sat_err    = 1'b0;
    if (bus.lookup_valid && !bus.flush_en) begin
      if (bus.lookup_is_fill) begin
        do_rel         = hit;
        set_orphan_err = !hit;
      end else if (bus.lookup_is_miss) begin
        do_merge      = hit;
        set_sat_err   = hit && (ent_cnt[match_idx] == '1);
        do_alloc      = !hit && any_free;
        set_alloc_err = !hit && !any_free;
      end
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    l2_miss_entry #(
      .KEY_WIDTH  (KEY_WIDTH),
      .MERGE_WIDTH(MERGE_WIDTH)
    ) u_ent (
      .clk   (clk),
      .reset (reset),
      .clear (bus.flush_en),
      .alloc (do_alloc && (free_idx == IDX_WIDTH'(g))),
      .rel   (do_rel && match[g]),
      .merge (do_merge && match[g]),
      .key_in(bus.lookup_addr),
      .vld   (ent_vld[g]),
      .key   (ent_key[g]),
      .cnt   (ent_cnt[g])
    );
  end

  always_comb begin
    occ_next = occ_q;
    if (bus.flush_en)  occ_next = '0;
    else if (do_alloc) occ_next = occ_q + 1'b1;
    else if (do_rel)   occ_next = occ_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q        <= '0;
      full_q       <= 1'b0;
      alloc_err_q  <= 1'b0;
      orphan_err_q <= 1'b0;
      sat_err_q    <= 1'b0;
    end else begin
      occ_q        <= occ_next;
      full_q       <= (occ_next >= FULL_LEVEL);
      alloc_err_q  <= alloc_err_q  | set_alloc_err;
      orphan_err_q <= orphan_err_q | set_orphan_err;
      sat_err_q    <= sat_err_q    | set_sat_err;
    end
  end

  assign bus.duplicate_request = bus.lookup_valid && hit;
  assign bus.lookup_idx        = hit ? match_idx : free_idx;
  assign bus.merge_count       = hit ? ent_cnt[match_idx] : '0;
  assign bus.occupancy         = occ_q;
  assign bus.tracker_full      = full_q;
  assign bus.alloc_error       = alloc_err_q;
  assign bus.orphan_fill_error = orphan_err_q;
  assign bus.merge_sat_error   = sat_err_q;
endmodule
